// File: rtl/pattern_gen_ser.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_gen_ser
//  Description : Serial pattern generator. Captures a DATA_W-bit word on an
//                accepted start and shifts out its low L bits, MSB- or
//                LSB-first, for rep+1 back-to-back passes. Outputs are
//                registered; a synchronous abort ends the burst early.
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_gen_ser #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int REP_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic [LEN_W-1:0]  len,
    input  logic              lsb_first,
    input  logic [REP_W-1:0]  rep,
    input  logic              abort,
    output logic              pattern,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W-1:0] c_full_len = LEN_W'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SHIFT  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_data;
    logic [LEN_W-1:0]   r_len;
    logic               r_lsb;
    logic [LEN_W-1:0]   r_idx;
    logic [REP_W-1:0]   r_pass;
    logic [LEN_W-1:0]   w_len_eff;
    logic [LEN_W-1:0]   w_idx_nxt;
    logic [REP_W-1:0]   w_pass_nxt;
    logic               w_capture;
    logic               w_wrap;
    logic               w_last_bit;
    logic               w_pattern_nxt;
    logic               w_valid_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // Stream bit at position idx of a pass; a right shift keeps the index
    // width independent of DATA_W.
    function automatic logic f_stream_bit(
        input logic [DATA_W-1:0] word,
        input logic [LEN_W-1:0]  length,
        input logic              lsb,
        input logic [LEN_W-1:0]  idx
    );
        logic [LEN_W-1:0]  pos;
        logic [DATA_W-1:0] shifted;
        pos     = lsb ? idx : (length - LEN_W'(1) - idx);
        shifted = word >> pos;
        return shifted[0];
    endfunction

    // Zero or oversize lengths fall back to the full word.
    assign w_len_eff  = ((len == '0) || (len > c_full_len)) ? c_full_len : len;
    assign w_wrap     = (r_idx == (r_len - LEN_W'(1)));
    assign w_last_bit = w_wrap && (r_pass == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, counter updates and next output values; abort overrides all.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_pass_nxt    = r_pass;
        w_capture     = 1'b0;
        w_pattern_nxt = 1'b0;
        w_valid_nxt   = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_LOAD;
                    w_capture   = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt   = S_SHIFT;
                    w_idx_nxt     = '0;
                    w_valid_nxt   = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_pattern_nxt = f_stream_bit(r_data, r_len, r_lsb, '0);
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_bit) begin
                    w_state_nxt = S_FINISH;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b1;
                end else begin
                    if (w_wrap) begin
                        w_idx_nxt  = '0;
                        w_pass_nxt = r_pass - REP_W'(1);
                    end else begin
                        w_idx_nxt  = r_idx + LEN_W'(1);
                    end
                    w_valid_nxt   = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_pattern_nxt = f_stream_bit(r_data, r_len, r_lsb, w_idx_nxt);
                end
            end
            S_FINISH: begin
                // Abort or not, FINISH always returns to IDLE with outputs low.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Burst parameters, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_len   <= '0;
            r_lsb   <= 1'b0;
            r_idx   <= '0;
            r_pass  <= '0;
            pattern <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_data <= data;
                r_len  <= w_len_eff;
                r_lsb  <= lsb_first;
                r_idx  <= '0;
                r_pass <= rep;
            end else begin
                r_idx  <= w_idx_nxt;
                r_pass <= w_pass_nxt;
            end
            pattern <= w_pattern_nxt;
            valid   <= w_valid_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_gen_ser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_gen_ser
//  Description : Self-checking bench for pattern_gen_ser. Expected stream
//                bits are queued when a burst is started and compared as the
//                DUT presents them with valid high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_gen_ser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = '0;
    logic [3:0] len = '0;
    logic       lsb_first = 1'b0;
    logic [2:0] rep = '0;
    logic       abort = 1'b0;
    logic       pattern;
    logic       valid;
    logic       busy;
    logic       done;

    int n_total   = 0;
    int n_pass    = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int exp_done  = 0;
    logic exp_q[$];

    pattern_gen_ser #(
        .DATA_W(8),
        .LEN_W (4),
        .REP_W (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data     (data),
        .len      (len),
        .lsb_first(lsb_first),
        .rep      (rep),
        .abort    (abort),
        .pattern  (pattern),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_len(input logic [3:0] l, input logic [2:0] r);
        int eff;
        eff = ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
        return eff * (int'(r) + 1);
    endfunction

    // Queue the expected stream (first max_bits bits of it).
    task automatic push_model(input logic [7:0] d, input logic [3:0] l, input logic lsb,
                              input logic [2:0] r, input int max_bits);
        int eff;
        int cnt;
        cnt = 0;
        eff = ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
        for (int p = 0; p <= int'(r); p++) begin
            for (int k = 0; k < eff; k++) begin
                if (cnt < max_bits) exp_q.push_back(lsb ? d[k] : d[eff-1-k]);
                cnt++;
            end
        end
    endtask

    // Scoreboard: every valid bit must match the head of the queue.
    always @(negedge clk) begin
        logic have;
        if (valid) begin
            have = (exp_q.size() > 0);
            check("sb_underflow", {31'd0, have}, 32'd1);
            if (have) check("sb_bit", {31'd0, pattern}, {31'd0, exp_q.pop_front()});
        end else begin
            check("idle_pattern", {31'd0, pattern}, 32'd0);
        end
        if (done) done_cnt++;
    end

    // Called right after the accepting edge: LOAD cycle, contiguous bits,
    // one FINISH cycle, then idle.
    task automatic measure(input int exp_bits, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        check({tag, "_load_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_load_valid"}, {31'd0, valid}, 32'd0);
        @(negedge clk);
        while (valid && n < 300) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_nbits"}, n, exp_bits);
        check({tag, "_fin_done"}, {31'd0, done}, 32'd1);
        check({tag, "_fin_busy"}, {31'd0, busy}, 32'd1);
        exp_done++;
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_burst(input logic [7:0] d, input logic [3:0] l, input logic lsb,
                             input logic [2:0] r, input string tag);
        push_model(d, l, lsb, r, 1000);
        data = d; len = l; lsb_first = lsb; rep = r; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        data = 8'($urandom); len = 4'($urandom); lsb_first = 1'($urandom); rep = 3'($urandom);
        measure(model_len(l, r), tag);
    endtask

    initial begin
        int g;
        int dn;
        repeat (3) @(negedge clk);
        check("rst_pattern", {31'd0, pattern}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_burst(8'hA5, 4'd8, 1'b0, 3'd0, "t1");
        run_burst(8'h0B, 4'd4, 1'b1, 3'd2, "t2");
        run_burst(8'h81, 4'd0, 1'b0, 3'd0, "t3a");
        run_burst(8'h81, 4'd12, 1'b0, 3'd0, "t3b");
        run_burst(8'h02, 4'd2, 1'b0, 3'd7, "trep");

        // Starts during SHIFT and FINISH are ignored; first IDLE cycle accepts.
        push_model(8'hC3, 4'd8, 1'b0, 3'd0, 1000);
        data = 8'hC3; len = 4'd8; lsb_first = 1'b0; rep = 3'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        data = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (!done && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("t4_done", {31'd0, done}, 32'd1);
        exp_done++;
        data = 8'h3C; start = 1'b1;
        @(negedge clk);
        check("t4_gap_busy", {31'd0, busy}, 32'd0);
        check("t4_gap_valid", {31'd0, valid}, 32'd0);
        data = 8'h5A;
        push_model(8'h5A, 4'd8, 1'b0, 3'd0, 1000);
        @(posedge clk);
        #1;
        start = 1'b0;
        measure(8, "t4b");

        // Abort on the third valid bit: no done afterwards.
        push_model(8'hA5, 4'd8, 1'b0, 3'd0, 3);
        data = 8'hA5; len = 4'd8; lsb_first = 1'b0; rep = 3'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("t5_bit3_valid", {31'd0, valid}, 32'd1);
        dn = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_ab_valid", {31'd0, valid}, 32'd0);
        check("t5_ab_busy", {31'd0, busy}, 32'd0);
        check("t5_ab_done", {31'd0, done}, 32'd0);
        repeat (12) @(negedge clk);
        check("t5_no_done", done_cnt, dn);

        // Start and abort together in IDLE: stays idle.
        data = 8'hFF; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("t5_sa_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("t5_sa_busy2", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-SHIFT clears outputs without a clock edge.
        push_model(8'hF0, 4'd8, 1'b0, 3'd1, 1000);
        data = 8'hF0; len = 4'd8; lsb_first = 1'b0; rep = 3'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("t6_rst_pattern", {31'd0, pattern}, 32'd0);
        check("t6_rst_valid", {31'd0, valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_burst(8'h96, 4'd5, 1'b1, 3'd1, "t6");

        repeat (2) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        check("done_total", done_cnt, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
